// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract scheduler.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    // Latency counter width; DP_LATENCY is bounded to 0..7.
    localparam int CNT_W = 3;

endpackage

// File: rtl/addsub_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ)
// and grants the first asserted request.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    // First valid requester after the last-served pointer wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = '0;
        if (enable) begin
            for (int unsigned off = 1; off <= NUM_REQ; off++) begin
                idx = ID_W'((32'(rr_ptr) + off) % NUM_REQ);
                if (!grant_valid && request[idx]) begin
                    grant[idx]  = 1'b1;
                    grant_id    = idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/addsub_scheduler.sv
// Round-robin scheduler sharing one add/subtract datapath between NUM_REQ
// requesters; one operation in flight at a time.
module addsub_scheduler
    import addsub_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 8,
    parameter int DP_LATENCY = 1,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         dp_a,
    output logic [WIDTH-1:0]         dp_b,
    output logic                     dp_sel,
    output logic                     dp_start,
    input  logic [WIDTH-1:0]         dp_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data
);

    localparam logic [CNT_W-1:0] CNT_LOAD =
        (DP_LATENCY == 0) ? '0 : CNT_W'(DP_LATENCY - 1);

    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    lat_id;
    logic               lat_op;
    logic [WIDTH-1:0]   lat_a;
    logic [WIDTH-1:0]   lat_b;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_valid;
    logic               arb_enable;

    assign arb_enable = (state == IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arbiter (
        .request     (req_valid),
        .rr_ptr      (rr_ptr),
        .enable      (arb_enable),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Operands and id are held in the latches, so the datapath inputs and
    // response id stay stable from ISSUE until the next grant.
    assign dp_a   = lat_a;
    assign dp_b   = lat_b;
    assign dp_sel = (lat_op == OP_SUB) ? SEL_SUB : SEL_ADD;
    assign rsp_id = lat_id;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (grant_valid) state_next = ISSUE;
            ISSUE: state_next = (DP_LATENCY == 0) ? RESP : WAIT;
            WAIT:  if (cnt == '0) state_next = RESP;
            RESP:  if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and strobe outputs decoded from the current state.
    always_comb begin
        req_ready = '0;
        dp_start  = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE:    req_ready = grant;
            ISSUE:   dp_start  = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request latches, latency counter, result capture and rotation pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= ID_W'(NUM_REQ - 1);
            lat_id   <= '0;
            lat_op   <= OP_ADD;
            lat_a    <= '0;
            lat_b    <= '0;
            cnt      <= '0;
            rsp_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        lat_id <= grant_id;
                        lat_op <= req_op[grant_id];
                        lat_a  <= req_a[grant_id*WIDTH +: WIDTH];
                        lat_b  <= req_b[grant_id*WIDTH +: WIDTH];
                    end
                end
                ISSUE: begin
                    cnt <= CNT_LOAD;
                    if (DP_LATENCY == 0) rsp_data <= dp_result;
                end
                WAIT: begin
                    if (cnt == '0) rsp_data <= dp_result;
                    else           cnt      <= cnt - 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rr_ptr <= lat_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_scheduler.sv
// Bench for addsub_scheduler: three instances (DP_LATENCY 1, 4, 0), only the
// selected one out of reset, checked each cycle against a transaction model.
module tb_addsub_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_ready;

    int          sel = 0;
    bit          cur_reset = 1'b1;
    logic        reset_1, reset_4, reset_0;
    assign reset_1 = (sel == 0) ? cur_reset : 1'b1;
    assign reset_4 = (sel == 1) ? cur_reset : 1'b1;
    assign reset_0 = (sel == 2) ? cur_reset : 1'b1;

    logic [3:0] ready_1, ready_4, ready_0;
    logic [7:0] dpa_1, dpa_4, dpa_0, dpb_1, dpb_4, dpb_0;
    logic       dpsel_1, dpsel_4, dpsel_0, start_1, start_4, start_0;
    logic [7:0] res_1, res_4, res_0;
    logic       rv_1, rv_4, rv_0;
    logic [1:0] rid_1, rid_4, rid_0;
    logic [7:0] rdata_1, rdata_4, rdata_0;

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic sub);
        return sub ? 8'(a - b) : 8'(a + b);
    endfunction

    // Behavioural datapaths: correct value appears exactly DP_LATENCY cycles
    // after dp_start, a corrupted value at every other time.
    always_ff @(posedge clk)
        res_1 <= start_1 ? alu(dpa_1, dpb_1, dpsel_1) : ~alu(dpa_1, dpb_1, dpsel_1);

    logic [7:0] d4 [4];
    always_ff @(posedge clk) begin
        d4[0] <= start_4 ? alu(dpa_4, dpb_4, dpsel_4) : ~alu(dpa_4, dpb_4, dpsel_4);
        d4[1] <= d4[0];
        d4[2] <= d4[1];
        d4[3] <= d4[2];
    end
    assign res_4 = d4[3];

    assign res_0 = start_0 ? alu(dpa_0, dpb_0, dpsel_0) : ~alu(dpa_0, dpb_0, dpsel_0);

    addsub_scheduler #(.NUM_REQ(4), .WIDTH(8), .DP_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset_1), .req_valid(req_valid), .req_ready(ready_1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .dp_a(dpa_1), .dp_b(dpb_1),
        .dp_sel(dpsel_1), .dp_start(start_1), .dp_result(res_1), .rsp_valid(rv_1),
        .rsp_ready(rsp_ready), .rsp_id(rid_1), .rsp_data(rdata_1));

    addsub_scheduler #(.NUM_REQ(4), .WIDTH(8), .DP_LATENCY(4)) u_dut_l4 (
        .clk(clk), .reset(reset_4), .req_valid(req_valid), .req_ready(ready_4),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .dp_a(dpa_4), .dp_b(dpb_4),
        .dp_sel(dpsel_4), .dp_start(start_4), .dp_result(res_4), .rsp_valid(rv_4),
        .rsp_ready(rsp_ready), .rsp_id(rid_4), .rsp_data(rdata_4));

    addsub_scheduler #(.NUM_REQ(4), .WIDTH(8), .DP_LATENCY(0)) u_dut_l0 (
        .clk(clk), .reset(reset_0), .req_valid(req_valid), .req_ready(ready_0),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .dp_a(dpa_0), .dp_b(dpb_0),
        .dp_sel(dpsel_0), .dp_start(start_0), .dp_result(res_0), .rsp_valid(rv_0),
        .rsp_ready(rsp_ready), .rsp_id(rid_0), .rsp_data(rdata_0));

    // Observed outputs of the currently selected instance.
    logic [3:0] o_ready;
    logic [7:0] o_dpa, o_dpb, o_rdata;
    logic       o_dpsel, o_start, o_rv;
    logic [1:0] o_rid;
    always_comb begin
        o_ready = ready_1; o_dpa = dpa_1; o_dpb = dpb_1; o_dpsel = dpsel_1;
        o_start = start_1; o_rv = rv_1; o_rid = rid_1; o_rdata = rdata_1;
        if (sel == 1) begin
            o_ready = ready_4; o_dpa = dpa_4; o_dpb = dpb_4; o_dpsel = dpsel_4;
            o_start = start_4; o_rv = rv_4; o_rid = rid_4; o_rdata = rdata_4;
        end else if (sel == 2) begin
            o_ready = ready_0; o_dpa = dpa_0; o_dpb = dpb_0; o_dpsel = dpsel_0;
            o_start = start_0; o_rv = rv_0; o_rid = rid_0; o_rdata = rdata_0;
        end
    end

    int checks = 0;
    int errors = 0;
    int lat_of [3] = '{1, 4, 0};
    int L = 1;

    // Requester-side state (what each client is presenting).
    logic [3:0] pv;
    logic       pop [4];
    logic [7:0] pa  [4];
    logic [7:0] pb  [4];

    // Transaction model: busy flag plus cycles since grant (1 = issue cycle).
    bit         m_busy;
    int         m_k;
    int         m_id;
    int         m_last;
    logic [7:0] m_a, m_b, m_res;
    logic       m_op;
    int         ops_done = 0;
    int         grant_log [$];
    logic [7:0] last_data;
    int         last_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_k    = 0;
        m_last = 3;
    endtask

    function automatic int pick();
        for (int off = 1; off <= 4; off++) begin
            int idx;
            idx = (m_last + off) % 4;
            if (pv[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic op, input logic [7:0] a, input logic [7:0] b);
        pv[i] = 1'b1; pop[i] = op; pa[i] = a; pb[i] = b;
    endtask

    task automatic new_rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    endtask

    // One clock: drive inputs, check outputs against the model, advance model.
    task automatic tick();
        int         g;
        logic [3:0] exp_ready;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]      = pv[i];
            req_op[i]         = pop[i];
            req_a[i*8 +: 8]   = pa[i];
            req_b[i*8 +: 8]   = pb[i];
        end
        #1;
        g = m_busy ? -1 : pick();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(o_ready), 32'(exp_ready));
        chk("dp_start", 32'(o_start), 32'(m_busy && m_k == 1));
        chk("rsp_valid", 32'(o_rv), 32'(m_busy && m_k >= L + 2));
        if (m_busy) begin
            chk("dp_a", 32'(o_dpa), 32'(m_a));
            chk("dp_b", 32'(o_dpb), 32'(m_b));
            chk("dp_sel", 32'(o_dpsel), 32'(m_op));
            if (m_k >= L + 2) begin
                chk("rsp_id", 32'(o_rid), 32'(m_id));
                chk("rsp_data", 32'(o_rdata), 32'(m_res));
            end
        end
        if (cur_reset) begin
            model_reset();
        end else if (!m_busy) begin
            if (g >= 0) begin
                m_busy = 1'b1; m_k = 1; m_id = g;
                m_a = pa[g]; m_b = pb[g]; m_op = pop[g];
                m_res = alu(pa[g], pb[g], pop[g]);
                pv[g] = 1'b0;
                grant_log.push_back(g);
            end
        end else if (m_k >= L + 2) begin
            if (rsp_ready) begin
                last_data = o_rdata;
                last_id   = int'(o_rid);
                m_busy    = 1'b0;
                m_last    = m_id;
                ops_done++;
            end
        end else begin
            m_k++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_ops(input int n, input int budget, input bit fill);
        int target;
        int cyc;
        target = ops_done + n;
        cyc    = 0;
        while (ops_done < target && cyc < budget) begin
            if (fill) for (int i = 0; i < 4; i++) if (!pv[i]) new_rand_req(i);
            tick();
            cyc++;
        end
        chk("ops_completed_in_budget", 32'(ops_done >= target), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(o_ready), 32'd0);
        chk({tag, "_dp_start"}, 32'(o_start), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(o_rv), 32'd0);
        chk({tag, "_dp_a"}, 32'(o_dpa), 32'd0);
        chk({tag, "_dp_b"}, 32'(o_dpb), 32'd0);
        chk({tag, "_dp_sel"}, 32'(o_dpsel), 32'd0);
        chk({tag, "_rsp_id"}, 32'(o_rid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(o_rdata), 32'd0);
    endtask

    task automatic select_dut(input int s);
        sel = s;
        L   = lat_of[s];
        pv  = '0;
        cur_reset = 1'b1;
        tick();
        tick();
        cur_reset = 1'b0;
        grant_log.delete();
    endtask

    initial begin
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        int cyc;
        pv = '0;
        for (int i = 0; i < 4; i++) begin pop[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state of every instance.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_zero($sformatf("reset%0d", s));
        end

        // Single add, then subtract with wrap and add with wrap (latency 1).
        select_dut(0);
        set_req(2, 1'b0, 8'h05, 8'h03);
        run_ops(1, 20, 1'b0);
        chk("add_data", 32'(last_data), 32'h08);
        chk("add_id", 32'(last_id), 32'd2);
        set_req(0, 1'b1, 8'h02, 8'h05);
        run_ops(1, 20, 1'b0);
        chk("sub_wrap_data", 32'(last_data), 32'hFD);
        set_req(0, 1'b0, 8'hFF, 8'h02);
        run_ops(1, 20, 1'b0);
        chk("add_wrap_data", 32'(last_data), 32'h01);

        // Round-robin with all requesters continuously valid from reset.
        select_dut(0);
        run_ops(5, 60, 1'b1);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order%0d", i),
                32'((grant_log.size() > i) ? grant_log[i] : -1), 32'(exp_ord[i]));

        // Backpressure: hold response for 5 cycles with other requests pending.
        pv = '0;
        tick();
        set_req(1, 1'b0, 8'h20, 8'h30);
        rsp_ready = 1'b0;
        cyc = 0;
        while (!(m_busy && m_k >= L + 2) && cyc < 20) begin tick(); cyc++; end
        set_req(0, 1'b1, 8'h11, 8'h22);
        set_req(3, 1'b0, 8'h33, 8'h44);
        repeat (5) tick();
        rsp_ready = 1'b1;
        run_ops(1, 10, 1'b0);
        chk("bp_data", 32'(last_data), 32'h50);
        run_ops(1, 20, 1'b0);
        chk("bp_next_grant", 32'(grant_log[grant_log.size()-1]), 32'd3);
        run_ops(1, 20, 1'b0);

        // Random traffic with drops and random backpressure.
        pv = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && $urandom_range(0, 3) == 0) new_rand_req(i);
                else if (pv[i] && $urandom_range(0, 31) == 0) pv[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rsp_ready = 1'b1;

        // Reset during WAIT on the latency-4 instance.
        select_dut(1);
        set_req(2, 1'b0, 8'h40, 8'h11);
        cyc = 0;
        while (!(m_busy && m_k == 2) && cyc < 20) begin tick(); cyc++; end
        cur_reset = 1'b1;
        tick();
        cur_reset = 1'b0;
        check_zero("midreset");
        set_req(0, 1'b1, 8'h09, 8'h04);
        set_req(3, 1'b0, 8'h07, 8'h08);
        run_ops(1, 20, 1'b0);
        chk("midreset_first_grant", 32'(grant_log[grant_log.size()-1]), 32'd0);
        chk("midreset_data", 32'(last_data), 32'h05);
        run_ops(1, 20, 1'b0);
        chk("midreset_second_id", 32'(last_id), 32'd3);

        // Zero-latency instance.
        select_dut(2);
        set_req(1, 1'b1, 8'h10, 8'h01);
        run_ops(1, 20, 1'b0);
        chk("lat0_data", 32'(last_data), 32'h0F);
        chk("lat0_id", 32'(last_id), 32'd1);
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < 4; i++)
                if (!pv[i] && $urandom_range(0, 2) == 0) new_rand_req(i);
            rsp_ready = ($urandom_range(0, 1) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_scheduler.md
Name: addsub_scheduler

Overview:
Round-robin scheduler that shares one 8-bit add/subtract datapath (adder, registered subtractor, result mux) between NUM_REQ requesters. It accepts one operation at a time over a valid/ready handshake and drives the datapath operands and mux select. It waits the datapath latency, then returns the tagged result over a valid/ready response channel. It sits between client blocks and the shared arithmetic datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width
DP_LATENCY, 1, datapath cycles from dp_start to valid dp_result (0..7)
ID_W, $clog2(NUM_REQ), requester id width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  one-hot accept strobe
req_op  input  NUM_REQ  per-requester op: 0 = add (a+b), 1 = sub (a-b)
req_a  input  NUM_REQ*WIDTH  flattened operand A, requester i at [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  flattened operand B, same packing
dp_a  output  WIDTH  operand A to datapath
dp_b  output  WIDTH  operand B to datapath
dp_sel  output  1  result mux select: 0 = adder, 1 = subtractor
dp_start  output  1  one-cycle pulse: operands valid this cycle
dp_result  input  WIDTH  datapath mux output
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  requester index of the response
rsp_data  output  WIDTH  result, modulo 2^WIDTH

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset values:
  - state = IDLE; rr_ptr = NUM_REQ-1, so requester 0 has top priority first.
  - req_ready = 0, dp_start = 0, rsp_valid = 0.
  - dp_a, dp_b, dp_sel, rsp_id, rsp_data all = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first valid index searching rr_ptr+1, rr_ptr+2, … (mod NUM_REQ).
  - Assert req_ready for the granted index only, in the same cycle (combinational from req_valid and rr_ptr).
  - Latch id, op, a, b. Go to ISSUE.
  - No valid request: stay in IDLE; req_ready = 0.
- ISSUE:
  - dp_a, dp_b, dp_sel driven from the latched values; they hold until IDLE is re-entered.
  - dp_start = 1 for exactly this cycle.
  - DP_LATENCY = 0: capture dp_result this cycle, go to RESP.
  - Otherwise load the counter with DP_LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture dp_result into rsp_data and go to RESP.
  - Total: rsp_valid first asserts DP_LATENCY+1 cycles after the ISSUE cycle.
- RESP:
  - rsp_valid = 1; rsp_id and rsp_data held stable until rsp_valid && rsp_ready.
  - On handshake: rr_ptr <= granted id, go to IDLE.
  - rsp_valid is not combinationally dependent on rsp_ready.
- Throughput: at most one op per DP_LATENCY+3 cycles; exactly one operation is in flight.
- Arithmetic: results wrap modulo 2^WIDTH; no carry/borrow output. The scheduler does no arithmetic itself.
- Requester rules:
  - A requester must hold its request (valid, op, a, b) stable until req_ready.
  - Dropping req_valid before grant is legal; it simply is not granted.
- Simultaneous events:
  - All requesters valid: strict rotation 0,1,2,3,0…
  - A request arriving during ISSUE/WAIT/RESP is not accepted until the next IDLE.
- Reset mid-operation: the in-flight op is discarded; no response is produced; the FSM returns to IDLE; rr_ptr is reset.
- rsp_ready held low indefinitely: stay in RESP; no new grants.

Decomposition:
- Shared package addsub_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - op constants OP_ADD = 1'b0, OP_SUB = 1'b1;
  - select constants SEL_ADD = 1'b0, SEL_SUB = 1'b1.
- One natural sub-module: rr_arbiter (NUM_REQ). Inputs: request vector, rr_ptr, enable. Output: one-hot grant plus encoded index; purely combinational.
- The FSM, operand latches and latency counter stay in addsub_scheduler.

Test Plan:
1. Single add: DP_LATENCY=1 behavioural datapath model. Req 2 valid, op=0, a=8'h05, b=8'h03 -> req_ready[2] pulses once; dp_start one cycle with dp_sel=0; rsp_valid 2 cycles after ISSUE, rsp_id=2, rsp_data=8'h08.
2. Sub wrap: req 0, op=1, a=8'h02, b=8'h05 -> dp_sel=1, rsp_data=8'hFD; add a=8'hFF, b=8'h02 -> rsp_data=8'h01.
3. Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> grant/rsp_id order 0,1,2,3,0; no requester granted twice before the others.
4. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable; req_ready stays 0 despite pending req_valid; grant follows the handshake.
5. Reset mid-op: assert reset in WAIT (DP_LATENCY=4) -> next cycle all outputs 0, no rsp_valid; a subsequent request from req 3 with reqs 0 and 3 valid -> req 0 granted first.
6. DP_LATENCY=0 build: a=8'h10, b=8'h01 sub -> rsp_valid the cycle after ISSUE, rsp_data=8'h0F.
